// File: rtl/pacman_arena.sv
// Pac-Man game core: constant wall map, ticked ghosts with per-ghost direction
// priority, handshake-driven Pac-Man, candies/score/lives and the game FSM.
module pacman_arena #(
   parameter int WIDTH        = 8,
   parameter int HEIGHT       = 8,
   parameter int NUM_GHOSTS   = 2,
   parameter int LIVES        = 3,
   parameter int GHOST_PERIOD = 2,
   parameter int SCORE_W      = 8,
   localparam int XW = $clog2(WIDTH),
   localparam int YW = $clog2(HEIGHT),
   localparam int LW = $clog2(LIVES + 1),
   localparam int CW = $clog2(WIDTH * HEIGHT + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         move_valid,
   input  logic [1:0]                   move,
   output logic [XW-1:0]                pacman_x,
   output logic [YW-1:0]                pacman_y,
   output logic [NUM_GHOSTS*XW-1:0]     ghost_x,
   output logic [NUM_GHOSTS*YW-1:0]     ghost_y,
   output logic [WIDTH*HEIGHT-1:0]      walls,
   output logic [WIDTH*HEIGHT-1:0]      candies,
   output logic [SCORE_W-1:0]           score,
   output logic [LW-1:0]                lives,
   output logic [CW-1:0]                candies_left,
   output logic [2:0]                   state,
   output logic                         game_over
);

   localparam int N     = WIDTH * HEIGHT;
   localparam int IW    = $clog2(N);
   localparam int TW    = (GHOST_PERIOD > 1) ? $clog2(GHOST_PERIOD) : 1;
   localparam int MINWH = (WIDTH < HEIGHT) ? WIDTH : HEIGHT;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PLAY    = 3'd1,
      S_RESPAWN = 3'd2,
      S_WON     = 3'd3,
      S_LOST    = 3'd4
   } state_t;

   function automatic logic is_wall(int x, int y);
      return (x == 0) || (x == WIDTH - 1) || (y == 0) || (y == HEIGHT - 1) ||
             ((x == y) && (x >= 2) && (x <= MINWH - 3));
   endfunction

   // Directions: 0=L, 1=U, 2=R, 3=D.
   function automatic int nb_x(int x, int d);
      return (d == 0) ? x - 1 : (d == 2) ? x + 1 : x;
   endfunction

   function automatic int nb_y(int y, int d);
      return (d == 1) ? y - 1 : (d == 3) ? y + 1 : y;
   endfunction

   function automatic int move_dir(logic [1:0] m);
      case (m)
         2'b00:   return 1;
         2'b01:   return 3;
         2'b10:   return 0;
         default: return 2;
      endcase
   endfunction

   function automatic logic [N-1:0] wall_map();
      logic [N-1:0] m;
      m = '0;
      for (int unsigned x = 0; x < WIDTH; x++)
         for (int unsigned y = 0; y < HEIGHT; y++)
            m[x*HEIGHT + y] = is_wall(int'(x), int'(y));
      return m;
   endfunction

   function automatic logic [NUM_GHOSTS*XW-1:0] ghost_x0();
      logic [NUM_GHOSTS*XW-1:0] v;
      v = '0;
      for (int unsigned g = 0; g < NUM_GHOSTS; g++) v[g*XW +: XW] = XW'(WIDTH - 2);
      return v;
   endfunction

   function automatic logic [NUM_GHOSTS*YW-1:0] ghost_y0();
      logic [NUM_GHOSTS*YW-1:0] v;
      v = '0;
      for (int unsigned g = 0; g < NUM_GHOSTS; g++) v[g*YW +: YW] = YW'(HEIGHT - 2 - int'(g));
      return v;
   endfunction

   localparam logic [N-1:0]             WALLS  = wall_map();
   localparam logic [N-1:0]             CANDY0 = ~WALLS & ~(N'(1) << (HEIGHT + 1));
   localparam logic [NUM_GHOSTS*XW-1:0] GX0    = ghost_x0();
   localparam logic [NUM_GHOSTS*YW-1:0] GY0    = ghost_y0();
   localparam logic [XW-1:0]            PX0    = XW'(1);
   localparam logic [YW-1:0]            PY0    = YW'(1);
   localparam logic [CW-1:0]            LEFT0  = CW'((WIDTH - 2) * (HEIGHT - 2) - (MINWH - 4) - 1);

   state_t                   state_q, state_d;
   logic [XW-1:0]            pac_x_q, pac_x_d, pac_nx;
   logic [YW-1:0]            pac_y_q, pac_y_d, pac_ny;
   logic [NUM_GHOSTS*XW-1:0] gx_q, gx_d, gx_nxt;
   logic [NUM_GHOSTS*YW-1:0] gy_q, gy_d, gy_nxt;
   logic [N-1:0]             candies_q, candies_d;
   logic [SCORE_W-1:0]       score_q, score_d;
   logic [LW-1:0]            lives_q, lives_d;
   logic [CW-1:0]            left_q, left_d;
   logic [TW-1:0]            tick_q, tick_d;
   logic                     ghost_tick, collide;
   logic [IW-1:0]            pac_idx;

   always_comb begin
      pac_nx = pac_x_q;
      pac_ny = pac_y_q;
      if (move_valid && !is_wall(nb_x(int'(pac_x_q), move_dir(move)),
                                 nb_y(int'(pac_y_q), move_dir(move)))) begin
         pac_nx = XW'(nb_x(int'(pac_x_q), move_dir(move)));
         pac_ny = YW'(nb_y(int'(pac_y_q), move_dir(move)));
      end
      pac_idx    = IW'(int'(pac_nx) * HEIGHT + int'(pac_ny));
      ghost_tick = (tick_q == TW'(GHOST_PERIOD - 1));
      gx_nxt     = gx_q;
      gy_nxt     = gy_q;
      collide    = 1'b0;
      for (int unsigned g = 0; g < NUM_GHOSTS; g++) begin
         // Scan priorities lowest-first so the highest free direction is written last.
         if (ghost_tick) begin
            for (int unsigned k = 4; k > 0; k--) begin
               if (!is_wall(nb_x(int'(gx_q[g*XW +: XW]), int'((g + k - 1) % 4)),
                            nb_y(int'(gy_q[g*YW +: YW]), int'((g + k - 1) % 4)))) begin
                  gx_nxt[g*XW +: XW] = XW'(nb_x(int'(gx_q[g*XW +: XW]), int'((g + k - 1) % 4)));
                  gy_nxt[g*YW +: YW] = YW'(nb_y(int'(gy_q[g*YW +: YW]), int'((g + k - 1) % 4)));
               end
            end
         end
         if ((gx_nxt[g*XW +: XW] == pac_nx && gy_nxt[g*YW +: YW] == pac_ny) ||
             (gx_nxt[g*XW +: XW] == pac_x_q && gy_nxt[g*YW +: YW] == pac_y_q &&
              gx_q[g*XW +: XW] == pac_nx && gy_q[g*YW +: YW] == pac_ny))
            collide = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      pac_x_d   = pac_x_q;
      pac_y_d   = pac_y_q;
      gx_d      = gx_q;
      gy_d      = gy_q;
      candies_d = candies_q;
      score_d   = score_q;
      lives_d   = lives_q;
      left_d    = left_q;
      tick_d    = tick_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_PLAY;
         S_PLAY: begin
            if (collide) begin
               lives_d = lives_q - 1'b1;
               pac_x_d = PX0;
               pac_y_d = PY0;
               gx_d    = GX0;
               gy_d    = GY0;
               tick_d  = '0;
               state_d = (lives_q == LW'(1)) ? S_LOST : S_RESPAWN;
            end else begin
               pac_x_d = pac_nx;
               pac_y_d = pac_ny;
               gx_d    = gx_nxt;
               gy_d    = gy_nxt;
               tick_d  = ghost_tick ? '0 : tick_q + 1'b1;
               if (candies_q[pac_idx]) begin
                  candies_d[pac_idx] = 1'b0;
                  left_d             = left_q - 1'b1;
                  if (score_q != '1) score_d = score_q + 1'b1;
                  if (left_q == CW'(1)) state_d = S_WON;
               end
            end
         end
         S_RESPAWN: state_d = S_PLAY;
         S_WON, S_LOST: begin
            if (start) begin
               state_d   = S_IDLE;
               pac_x_d   = PX0;
               pac_y_d   = PY0;
               gx_d      = GX0;
               gy_d      = GY0;
               candies_d = CANDY0;
               score_d   = '0;
               lives_d   = LW'(LIVES);
               left_d    = LEFT0;
               tick_d    = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pac_x_q   <= PX0;
         pac_y_q   <= PY0;
         gx_q      <= GX0;
         gy_q      <= GY0;
         candies_q <= CANDY0;
         score_q   <= '0;
         lives_q   <= LW'(LIVES);
         left_q    <= LEFT0;
         tick_q    <= '0;
      end else begin
         state_q   <= state_d;
         pac_x_q   <= pac_x_d;
         pac_y_q   <= pac_y_d;
         gx_q      <= gx_d;
         gy_q      <= gy_d;
         candies_q <= candies_d;
         score_q   <= score_d;
         lives_q   <= lives_d;
         left_q    <= left_d;
         tick_q    <= tick_d;
      end
   end

   assign pacman_x     = pac_x_q;
   assign pacman_y     = pac_y_q;
   assign ghost_x      = gx_q;
   assign ghost_y      = gy_q;
   assign walls        = WALLS;
   assign candies      = candies_q;
   assign score        = score_q;
   assign lives        = lives_q;
   assign candies_left = left_q;
   assign state        = state_q;
   assign game_over    = (state_q == S_WON) || (state_q == S_LOST);

endmodule

// File: doc/pacman_arena.md
# pacman_arena

Parametrised next-generation Pac-Man game core: a generated wall map, NUM_GHOSTS ghosts with per-ghost direction priority, a lives counter, a saturating score and a game FSM (idle/play/respawn/won/lost). Pac-Man moves only on a valid/move handshake. Ghosts move on a programmable tick. Collision detection includes head-on swaps. The block is the top-level game engine; a display or formal harness observes its outputs.

## Interface
- WIDTH, 8: grid columns; must be ≥ 7.
- HEIGHT, 8: grid rows; must be ≥ 7.
- NUM_GHOSTS, 2: ghost count, 1..HEIGHT-2.
- LIVES, 3: lives at game start, ≥ 1.
- GHOST_PERIOD, 2: PLAY cycles per ghost step, ≥ 1.
- SCORE_W, 8: score width.
- Derived widths:
  - XW = $clog2(WIDTH), YW = $clog2(HEIGHT).
  - LW = $clog2(LIVES+1).
  - CW = $clog2(WIDTH*HEIGHT+1).
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  start game (IDLE), or restart (WON/LOST).
- move_valid  in  1  move request this cycle.
- move  in  2  00=up (y-1), 01=down (y+1), 10=left (x-1), 11=right (x+1).
- pacman_x / pacman_y  out  XW / YW  Pac-Man position.
- ghost_x / ghost_y  out  NUM_GHOSTS*XW / NUM_GHOSTS*YW  ghost g in slice [g*XW +: XW] / [g*YW +: YW].
- walls  out  WIDTH*HEIGHT  bit x*HEIGHT+y; 1 = wall.
- candies  out  WIDTH*HEIGHT  same indexing; 1 = candy.
- score  out  SCORE_W  candies eaten, saturating.
- lives  out  LW  remaining lives.
- candies_left  out  CW  count of set candies bits.
- state  out  3  IDLE=0, PLAY=1, RESPAWN=2, WON=3, LOST=4.
- game_over  out  1  state is WON or LOST.

## Operation
- Walls are constant:
  - the full border;
  - diagonal cells (k,k) for k = 2 .. min(WIDTH,HEIGHT)-3.
- Reset, or start while in WON/LOST, sets:
  - state=IDLE, pacman=(1,1), ghost g=(WIDTH-2, HEIGHT-2-g);
  - candies = all free cells except (1,1);
  - candies_left = (WIDTH-2)(HEIGHT-2) - (min(WIDTH,HEIGHT)-4) - 1 (defaults: 31);
  - score=0, lives=LIVES, ghost tick counter=0.
- IDLE: nothing moves; start moves to PLAY.
- PLAY, every cycle:
  - pac_next = neighbour in direction move if move_valid and that neighbour is not a wall; otherwise pac_cur.
  - Tick counter increments and wraps at GHOST_PERIOD-1. Ghosts step only in the wrap cycle.
  - Ghost step: base order L, U, R, D, rotated to start at index g mod 4. The ghost takes the first non-wall direction. Ghost-ghost overlap is allowed.
  - collide = any g with ghost_next==pac_next, or swap (ghost_next==pac_cur and ghost_cur==pac_next).
- PLAY, on collide:
  - lives decrements; candies and score are unchanged.
  - All positions reload their start values; tick counter clears.
  - Next state is LOST if lives was 1, else RESPAWN.
- PLAY, no collide:
  - Positions update.
  - If candies[pac_next]=1: clear it, candies_left-1, score+1 (saturates at all-ones).
  - If candies_left reaches 0, next state is WON.
- RESPAWN: lasts exactly 1 cycle, then PLAY. No movement and no eating.
- WON/LOST: all state is frozen. move_valid is ignored. start re-initialises as at reset.
- rst takes priority over every input and state.

## Timing
- All outputs are registered. A position, candy, score or state change is visible the cycle after the triggering edge.
- Move latency is 1 cycle. Ghost steps in PLAY occur on PLAY cycles GHOST_PERIOD-1, 2*GHOST_PERIOD-1, … after PLAY entry or respawn.
- start→PLAY takes 1 cycle. Collision→RESPAWN→PLAY takes 2 cycles.
- Collision and last-candy in the same cycle: collision wins, the candy is not eaten, and the state does not go to WON.
- rst asserted mid-game restores the reset values at the next edge.

## Test plan
- Reset, defaults:
  - pacman=(1,1), ghost0=(6,6), ghost1=(6,5);
  - candies_left=31, lives=3, score=0, state=0;
  - walls[2*8+2]=1, candies[1*8+1]=0.
- Cycle after start, then move_valid=1, move=11:
  - pacman=(2,1), score=1, candies_left=30, candies[2*8+1]=0.
  - Revisiting (2,1) leaves score unchanged.
- From (1,1), move=00 → position unchanged (wall at (1,0)). move_valid=0 with move=11 → position unchanged.
- First ghost tick (2nd PLAY cycle) → ghost0=(5,6) (L), ghost1=(6,4) (U). No ghost movement on the 1st PLAY cycle.
- Steer Pac-Man into a ghost, both direct overlap and swap:
  - lives 3→2, state=2 for one cycle then 1;
  - positions at their start values, candies_left unchanged.
- Three collisions → state=4, game_over=1.
  - Further moves ignored; start → state=0 with full reset values.
- SCORE_W=2, eat 4 candies → score stays at 3, candies_left decrements by 4.
